// File: rtl/mm_result_collector_if.sv
// Handshake bundle between the matmul datapath, the result collector and the vector consumer.
// slave is the collector's view; master is the producer/consumer side.
interface mm_result_collector_if #(
   parameter int N     = 8,
   parameter int ACC_W = 19,
   parameter int OUT_W = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [ACC_W-1:0]     in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [N*OUT_W-1:0]   out_data;
   logic [N-1:0]         out_sat;
   logic [15:0]          frame_cnt;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat, frame_cnt
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat, frame_cnt
   );
endinterface

// File: rtl/mm_result_collector.sv
// Saturates serial accumulator results and packs N of them per vector in a ping-pong buffer.
// Last element accepted in cycle T shows out_valid in T+1; in_ready depends only on registered full flags.
module mm_result_collector #(
   parameter int N     = 8,
   parameter int ACC_W = 19,
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   mm_result_collector_if.slave    bus
);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [N*OUT_W-1:0] data_q [2];
   logic [N-1:0]       sat_q  [2];
   logic [1:0]         full_q;
   logic               wr_bank;
   logic               rd_bank;
   logic [CNT_W-1:0]   elem_cnt;
   logic [15:0]        frame_cnt_q;

   logic               accept;
   logic               drain;
   logic               last_elem;
   logic [OUT_W-1:0]   sat_val;
   logic               sat_bit;

   always_comb begin
      sat_val = bus.in_data[OUT_W-1:0];
      sat_bit = 1'b0;
      if ($signed(bus.in_data) > MAX_V) begin
         sat_val = MAX_V[OUT_W-1:0];
         sat_bit = 1'b1;
      end else if ($signed(bus.in_data) < MIN_V) begin
         sat_val = MIN_V[OUT_W-1:0];
         sat_bit = 1'b1;
      end
   end

   assign bus.in_ready  = ~full_q[wr_bank];
   assign bus.out_valid = full_q[rd_bank];
   assign bus.out_data  = data_q[rd_bank];
   assign bus.out_sat   = sat_q[rd_bank];
   assign bus.frame_cnt = frame_cnt_q;

   assign accept    = bus.in_valid & ~full_q[wr_bank];
   assign drain     = full_q[rd_bank] & bus.out_ready;
   assign last_elem = (elem_cnt == CNT_W'(N - 1));

   // Fill and drain always target different banks, so their full-flag updates never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q      <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         elem_cnt    <= '0;
         frame_cnt_q <= '0;
         for (int b = 0; b < 2; b++) begin
            data_q[b] <= '0;
            sat_q[b]  <= '0;
         end
      end else begin
         if (accept) begin
            data_q[wr_bank][int'(elem_cnt)*OUT_W +: OUT_W] <= sat_val;
            sat_q[wr_bank][elem_cnt]                       <= sat_bit;
            if (last_elem) begin
               elem_cnt        <= '0;
               full_q[wr_bank] <= 1'b1;
               wr_bank         <= ~wr_bank;
            end else begin
               elem_cnt <= elem_cnt + 1'b1;
            end
         end
         if (drain) begin
            full_q[rd_bank] <= 1'b0;
            rd_bank         <= ~rd_bank;
            frame_cnt_q     <= frame_cnt_q + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_mm_result_collector.sv
// Directed bench for mm_result_collector: table-driven frames plus backpressure, ping-pong, reset and wrap sequences.
module tb_mm_result_collector;
   localparam int N = 8, ACC_W = 19, OUT_W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mm_result_collector_if #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

   mm_result_collector #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic signed [ACC_W-1:0] din;
      logic [OUT_W-1:0]        exp;
      logic                    sat;
   } vec_t;

   vec_t        tbl [24];
   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] exp_frames = 16'd0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feeds frame f from the table with out_ready high and checks the packed vector and its drain.
   task automatic feed_frame(input int f, input string nm);
      logic [127:0] e_dat;
      logic [7:0]   e_sat;
      e_dat = '0;
      e_sat = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         e_dat[i*OUT_W +: OUT_W] = tbl[f*N+i].exp;
         e_sat[i]                = tbl[f*N+i].sat;
         bus.in_valid = 1'b1;
         bus.in_data  = tbl[f*N+i].din;
         if (i == N-1) chk({nm, "_valid_before_last"}, 128'(bus.out_valid), 128'(0));
         chk({nm, "_in_ready"}, 128'(bus.in_ready), 128'(1));
         tick();
      end
      bus.in_valid = 1'b0;
      chk({nm, "_out_valid"}, 128'(bus.out_valid), 128'(1));
      chk({nm, "_out_data"}, bus.out_data, e_dat);
      chk({nm, "_out_sat"}, 128'(bus.out_sat), 128'(e_sat));
      tick();
      exp_frames++;
      chk({nm, "_frame_cnt"}, 128'(bus.frame_cnt), 128'(exp_frames));
      chk({nm, "_drained"}, 128'(bus.out_valid), 128'(0));
   endtask

   initial begin
      logic [127:0] exp_a, exp_b, e;
      int acc, obs, sent, rcv;
      logic exp_rdy;

      for (int i = 0; i < N; i++) begin
         tbl[i]      = '{din: ACC_W'(i+1),    exp: OUT_W'(i+1),    sat: 1'b0};
         tbl[16+i]   = '{din: ACC_W'(2000+i), exp: OUT_W'(2000+i), sat: 1'b0};
      end
      tbl[8]  = '{din:  19'sd40000, exp: 16'h7FFF, sat: 1'b1};
      tbl[9]  = '{din: -19'sd40000, exp: 16'h8000, sat: 1'b1};
      tbl[10] = '{din:  19'sd32767, exp: 16'h7FFF, sat: 1'b0};
      tbl[11] = '{din: -19'sd32768, exp: 16'h8000, sat: 1'b0};
      tbl[12] = '{din:  19'sd0,     exp: 16'h0000, sat: 1'b0};
      tbl[13] = '{din:  19'sd5,     exp: 16'h0005, sat: 1'b0};
      tbl[14] = '{din: -19'sd5,     exp: 16'hFFFB, sat: 1'b0};
      tbl[15] = '{din:  19'sd100,   exp: 16'h0064, sat: 1'b0};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_out_data",  bus.out_data,        128'(0));
      chk("rst_out_sat",   128'(bus.out_sat),   128'(0));
      chk("rst_frame_cnt", 128'(bus.frame_cnt), 128'(0));

      feed_frame(0, "single");
      feed_frame(1, "satur");

      // Backpressure: 24 offered, only 16 fit; frame A must sit stable on the output.
      exp_a = '0;
      exp_b = '0;
      for (int i = 0; i < N; i++) begin
         exp_a[i*OUT_W +: OUT_W] = OUT_W'(100+i);
         exp_b[i*OUT_W +: OUT_W] = OUT_W'(108+i);
      end
      acc = 0;
      obs = 0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 24; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = ACC_W'(100+acc);
         exp_rdy = (acc < 2*N);
         chk("bp_in_ready", 128'(bus.in_ready), 128'(exp_rdy));
         if (acc >= N) begin
            chk("bp_hold_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_hold_data",  bus.out_data,        exp_a);
         end
         if (bus.in_ready) obs++;
         if (exp_rdy) acc++;
         tick();
      end
      chk("bp_accepted", 128'(obs), 128'(16));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_both_full_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_frame_a", bus.out_data, exp_a);
      tick();
      exp_frames++;
      chk("bp_frame_b_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_frame_b", bus.out_data, exp_b);
      chk("bp_ready_back", 128'(bus.in_ready), 128'(1));
      chk("bp_cnt_a", 128'(bus.frame_cnt), 128'(exp_frames));
      tick();
      exp_frames++;
      chk("bp_empty", 128'(bus.out_valid), 128'(0));
      chk("bp_cnt_b", 128'(bus.frame_cnt), 128'(exp_frames));

      // Ping-pong: continuous input, consumer ready every other cycle, 10 frames.
      sent = 0;
      rcv  = 0;
      for (int c = 0; c < 400 && rcv < 10; c++) begin
         bus.in_valid  = (sent < 10*N);
         bus.in_data   = ACC_W'(1000+sent);
         bus.out_ready = c[0];
         if (bus.out_valid && bus.out_ready) begin
            e = '0;
            for (int i = 0; i < N; i++) e[i*OUT_W +: OUT_W] = OUT_W'(1000 + rcv*N + i);
            chk("pp_vector", bus.out_data, e);
            rcv++;
            exp_frames++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("pp_frames", 128'(rcv), 128'(10));
      chk("pp_sent", 128'(sent), 128'(80));
      chk("pp_frame_cnt", 128'(bus.frame_cnt), 128'(exp_frames));
      tick();
      chk("pp_no_extra", 128'(bus.out_valid), 128'(0));

      // Reset mid-frame discards the partial frame.
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = ACC_W'(500+i);
         tick();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_frames = 16'd0;
      chk("mr_out_valid", 128'(bus.out_valid), 128'(0));
      chk("mr_frame_cnt", 128'(bus.frame_cnt), 128'(0));
      feed_frame(2, "after_rst");
      repeat (3) tick();
      chk("mr_no_stale", 128'(bus.out_valid), 128'(0));

      // Wrap: preload the frame counter just below rollover.
      force dut.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
      exp_frames = 16'hFFFF;
      chk("wrap_preload", 128'(bus.frame_cnt), 128'(16'hFFFF));
      feed_frame(0, "wrap");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
